// File: rtl/hwpe_ctrl_job_queue.sv
// rtl/hwpe_ctrl_job_queue.sv - HWPE job-offload controller with a circular job-slot ring
// Cores acquire/commit jobs over the config port; committed jobs run on the engine in commit order.
module hwpe_ctrl_job_queue #(
  parameter int unsigned  N_CORES      = 8,
  parameter int unsigned  N_CONTEXT    = 4,
  parameter int unsigned  N_SW_EVT     = 8,
  parameter int unsigned  ID_WIDTH     = 8,
  parameter int unsigned  DATA_WIDTH   = 32,
  parameter bit           AUTO_TRIGGER = 1'b0,
  localparam int unsigned LOG_CTX      = $clog2(N_CONTEXT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_req_i,
  output logic                  cfg_gnt_o,
  input  logic [7:0]            cfg_add_i,
  input  logic                  cfg_wen_i,
  input  logic [3:0]            cfg_be_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic [ID_WIDTH-1:0]   cfg_id_i,
  output logic                  cfg_r_valid_o,
  output logic [DATA_WIDTH-1:0] cfg_r_data_o,
  output logic [ID_WIDTH-1:0]   cfg_r_id_o,
  output logic                  prog_valid_o,
  output logic [LOG_CTX-1:0]    prog_ctx_o,
  output logic                  start_o,
  output logic                  busy_o,
  output logic [LOG_CTX-1:0]    ctx_o,
  output logic [7:0]            job_id_o,
  input  logic                  done_i,
  output logic [N_CORES-1:0]    evt_o,
  output logic [N_SW_EVT-1:0]   sw_evt_o,
  output logic                  clear_o
);

  localparam int unsigned SW_IDX = (N_SW_EVT > 1) ? $clog2(N_SW_EVT) : 1;
  localparam logic [LOG_CTX:0] PEND_FULL = (LOG_CTX+1)'(N_CONTEXT);
  localparam logic [2:0] OFF_TRIGGER    = 3'd0;
  localparam logic [2:0] OFF_ACQUIRE    = 3'd1;
  localparam logic [2:0] OFF_FINISHED   = 3'd2;
  localparam logic [2:0] OFF_STATUS     = 3'd3;
  localparam logic [2:0] OFF_RUNNING    = 3'd4;
  localparam logic [2:0] OFF_SOFT_CLEAR = 3'd5;
  localparam logic [2:0] OFF_SWEVT      = 3'd6;
  localparam logic [DATA_WIDTH-1:0] RESP_LOCKED = '1;
  localparam logic [DATA_WIDTH-1:0] RESP_FULL   = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, STARTING, RUN} state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d, start_q, start_d;
  logic [LOG_CTX-1:0]    head_q, head_d, tail_q, tail_d;
  logic [LOG_CTX:0]      pending_q, pending_d;
  logic                  critical_q, critical_d, triggered_q, triggered_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [7:0]            next_id_q, next_id_d;
  logic [DATA_WIDTH-1:0] finished_q, finished_d;
  logic [ID_WIDTH-1:0]   slot_owner_q [N_CONTEXT];
  logic [ID_WIDTH-1:0]   slot_owner_d [N_CONTEXT];
  logic [7:0]            slot_id_q [N_CONTEXT];
  logic [7:0]            slot_id_d [N_CONTEXT];
  logic [N_CORES-1:0]    done_evt_q, done_evt_d, evt_q, evt_d;
  logic [N_SW_EVT-1:0]   sw_evt_q, sw_evt_d;
  logic [1:0]            clear_cnt_q, clear_cnt_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;

  logic [2:0]            off;
  logic                  rd, wr, is_owner, data_zero, acq_grant, commit, set_trig;
  logic                  soft_clr, clear_active, done_ok;
  logic [DATA_WIDTH-1:0] status;
  logic                  unused_bits;

  assign unused_bits = ^{cfg_be_i, cfg_add_i[7:5], cfg_add_i[1:0]};

  assign off          = cfg_add_i[4:2];
  assign rd           = cfg_req_i && cfg_wen_i && !clear_o;
  // Writes landing while a soft clear is in progress are dropped entirely.
  assign wr           = cfg_req_i && !cfg_wen_i && !clear_o;
  assign is_owner     = critical_q && (cfg_id_i == owner_q);
  assign data_zero    = (cfg_data_i == '0);
  assign acq_grant    = rd && (off == OFF_ACQUIRE) && !critical_q && (pending_q != PEND_FULL);
  assign commit       = wr && (off == OFF_TRIGGER) && is_owner;
  assign set_trig     = wr && (off == OFF_TRIGGER) &&
                        (commit ? (data_zero || AUTO_TRIGGER) : (!critical_q && data_zero));
  assign soft_clr     = wr && (off == OFF_SOFT_CLEAR);
  assign clear_active = soft_clr || clear_o;
  assign done_ok      = (state_q == RUN) && done_i;

  always_comb begin
    status              = '0;
    status[LOG_CTX:0]   = pending_q;
    status[8]           = busy_q;
    status[9]           = critical_q;
    status[10]          = triggered_q;
    status[23:16]       = job_id_o;
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    start_d      = 1'b0;
    head_d       = head_q;
    tail_d       = tail_q + LOG_CTX'(done_ok);
    pending_d    = pending_q;
    critical_d   = critical_q;
    triggered_d  = triggered_q;
    owner_d      = owner_q;
    next_id_d    = next_id_q;
    finished_d   = finished_q + DATA_WIDTH'(done_ok);
    slot_owner_d = slot_owner_q;
    slot_id_d    = slot_id_q;
    done_evt_d   = done_ok ? (N_CORES'(1) << slot_owner_q[tail_q]) : '0;
    evt_d        = done_evt_q;
    sw_evt_d     = '0;
    clear_cnt_d  = (clear_cnt_q != 2'd0) ? clear_cnt_q - 2'd1 : 2'd0;
    r_valid_d    = cfg_req_i;
    r_id_d       = cfg_id_i;
    r_data_d     = '0;

    unique case (state_q)
      IDLE: if (pending_q != '0 && triggered_q) begin
        state_d = STARTING;
        busy_d  = 1'b1;
      end
      STARTING: begin
        state_d = RUN;
        start_d = 1'b1;
      end
      RUN: if (done_i) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (acq_grant) begin
      critical_d = 1'b1;
      owner_d    = cfg_id_i;
    end
    if (commit) begin
      slot_owner_d[head_q] = owner_q;
      slot_id_d[head_q]    = next_id_q;
      head_d               = head_q + LOG_CTX'(1);
      next_id_d            = next_id_q + 8'd1;
      critical_d           = 1'b0;
    end
    case ({commit, done_ok})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
    if (set_trig) triggered_d = 1'b1;
    else if (done_ok && pending_d == '0) triggered_d = 1'b0;

    if (wr && off == OFF_SWEVT && cfg_data_i < DATA_WIDTH'(N_SW_EVT))
      sw_evt_d[cfg_data_i[SW_IDX-1:0]] = 1'b1;

    if (rd) begin
      unique case (off)
        OFF_ACQUIRE:  r_data_d = !critical_q ? ((pending_q == PEND_FULL) ? RESP_FULL : DATA_WIDTH'(next_id_q))
                                             : (is_owner ? DATA_WIDTH'(next_id_q) : RESP_LOCKED);
        OFF_FINISHED: r_data_d = finished_q;
        OFF_STATUS:   r_data_d = status;
        OFF_RUNNING:  r_data_d = busy_q ? DATA_WIDTH'(job_id_o) : RESP_LOCKED;
        default:      r_data_d = '0;
      endcase
    end

    if (soft_clr) begin
      clear_cnt_d = 2'd2;
      if (data_zero) next_id_d = '0;
    end
    // The accepting edge and both clear cycles hold the queue and engine side at reset.
    if (clear_active) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      start_d     = 1'b0;
      head_d      = '0;
      tail_d      = '0;
      pending_d   = '0;
      critical_d  = 1'b0;
      triggered_d = 1'b0;
      finished_d  = '0;
      done_evt_d  = '0;
      evt_d       = '0;
      sw_evt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      pending_q   <= '0;
      critical_q  <= 1'b0;
      triggered_q <= 1'b0;
      owner_q     <= '0;
      next_id_q   <= '0;
      finished_q  <= '0;
      for (int i = 0; i < N_CONTEXT; i++) begin
        slot_owner_q[i] <= '0;
        slot_id_q[i]    <= '0;
      end
      done_evt_q  <= '0;
      evt_q       <= '0;
      sw_evt_q    <= '0;
      clear_cnt_q <= '0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_id_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      pending_q    <= pending_d;
      critical_q   <= critical_d;
      triggered_q  <= triggered_d;
      owner_q      <= owner_d;
      next_id_q    <= next_id_d;
      finished_q   <= finished_d;
      slot_owner_q <= slot_owner_d;
      slot_id_q    <= slot_id_d;
      done_evt_q   <= done_evt_d;
      evt_q        <= evt_d;
      sw_evt_q     <= sw_evt_d;
      clear_cnt_q  <= clear_cnt_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_id_q       <= r_id_d;
    end
  end

  assign cfg_gnt_o     = 1'b1;
  assign cfg_r_valid_o = r_valid_q;
  assign cfg_r_data_o  = r_data_q;
  assign cfg_r_id_o    = r_id_q;
  assign prog_valid_o  = critical_q;
  assign prog_ctx_o    = head_q;
  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign ctx_o         = tail_q;
  assign job_id_o      = slot_id_q[tail_q];
  assign evt_o         = evt_q;
  assign sw_evt_o      = sw_evt_q;
  assign clear_o       = (clear_cnt_q != 2'd0);

endmodule

// File: tb/tb_hwpe_ctrl_job_queue.sv
// tb/tb_hwpe_ctrl_job_queue.sv - self-checking bench for hwpe_ctrl_job_queue
// Directed table, multi-cycle corner sequences and a queue-based random reference model.
module tb_hwpe_ctrl_job_queue;

  localparam logic [2:0] OFF_TRIGGER = 3'd0, OFF_ACQUIRE = 3'd1, OFF_FINISHED = 3'd2,
                         OFF_STATUS  = 3'd3, OFF_RUNNING = 3'd4, OFF_SOFT_CLEAR = 3'd5,
                         OFF_SWEVT   = 3'd6;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_req_i = 1'b0, cfg_wen_i = 1'b0;
  logic [7:0]  cfg_add_i = '0;
  logic [3:0]  cfg_be_i = 4'hf;
  logic [31:0] cfg_data_i = '0;
  logic [7:0]  cfg_id_i = '0;
  logic        done_i = 1'b0, done_a = 1'b0;

  logic        cfg_gnt_o, cfg_r_valid_o, prog_valid_o, start_o, busy_o, clear_o;
  logic [31:0] cfg_r_data_o;
  logic [7:0]  cfg_r_id_o, job_id_o, evt_o, sw_evt_o;
  logic [1:0]  prog_ctx_o, ctx_o;

  logic        gnt_a, r_valid_a, prog_valid_a, start_a, busy_a, clear_a;
  logic [31:0] r_data_a;
  logic [7:0]  r_id_a, job_id_a, evt_a, sw_evt_a;
  logic [1:0]  prog_ctx_a, ctx_a;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] evt_seen;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_job_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o),
    .cfg_add_i(cfg_add_i), .cfg_wen_i(cfg_wen_i), .cfg_be_i(cfg_be_i), .cfg_data_i(cfg_data_i),
    .cfg_id_i(cfg_id_i), .cfg_r_valid_o(cfg_r_valid_o), .cfg_r_data_o(cfg_r_data_o),
    .cfg_r_id_o(cfg_r_id_o), .prog_valid_o(prog_valid_o), .prog_ctx_o(prog_ctx_o),
    .start_o(start_o), .busy_o(busy_o), .ctx_o(ctx_o), .job_id_o(job_id_o), .done_i(done_i),
    .evt_o(evt_o), .sw_evt_o(sw_evt_o), .clear_o(clear_o)
  );

  hwpe_ctrl_job_queue #(.AUTO_TRIGGER(1'b1)) dut_auto (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_req_i(cfg_req_i), .cfg_gnt_o(gnt_a),
    .cfg_add_i(cfg_add_i), .cfg_wen_i(cfg_wen_i), .cfg_be_i(cfg_be_i), .cfg_data_i(cfg_data_i),
    .cfg_id_i(cfg_id_i), .cfg_r_valid_o(r_valid_a), .cfg_r_data_o(r_data_a),
    .cfg_r_id_o(r_id_a), .prog_valid_o(prog_valid_a), .prog_ctx_o(prog_ctx_a),
    .start_o(start_a), .busy_o(busy_a), .ctx_o(ctx_a), .job_id_o(job_id_a), .done_i(done_a),
    .evt_o(evt_a), .sw_evt_o(sw_evt_a), .clear_o(clear_a)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    evt_seen |= evt_o;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; cfg_req_i = 1'b0; done_i = 1'b0; done_a = 1'b0;
    cycles(2);
    rst_ni = 1'b1;
    step();
  endtask

  task automatic access(input int core, input bit rd, input logic [2:0] off, input logic [31:0] data,
                        input bit with_done, output logic [31:0] rdata, output logic [31:0] rdata_a);
    cfg_req_i = 1'b1; cfg_wen_i = rd; cfg_add_i = {3'b000, off, 2'b00};
    cfg_data_i = data; cfg_id_i = 8'(core); done_i = with_done;
    step();
    cfg_req_i = 1'b0; done_i = 1'b0;
    rdata = cfg_r_data_o;
    rdata_a = r_data_a;
    check("r_valid", {31'b0, cfg_r_valid_o}, 32'd1);
    check("r_id", {24'b0, cfg_r_id_o}, core);
  endtask

  task automatic wait_start(input string name, output logic [7:0] jid);
    bit found;
    found = 1'b0;
    jid = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (start_o) begin found = 1'b1; jid = job_id_o; end
    end
    check({name, "_start_seen"}, {31'b0, found}, 32'd1);
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
  endtask

  typedef struct {
    int          core;
    bit          rd;
    logic [2:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int         owner;
    logic [7:0] id;
  } job_t;

  vec_t tbl[22];
  job_t mq[$];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] r, ra, exp, mask;
    logic [7:0]  jid;
    int          owners[4];
    bit          found;
    int          op, c;
    logic [31:0] d;
    bit          m_crit, m_trig, m_run;
    int          m_owner;
    logic [7:0]  m_next;
    logic [31:0] m_fin;
    job_t        j;

    // Reset state while rst_ni is held low.
    #1;
    check("rst_gnt", {31'b0, cfg_gnt_o}, 1);
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_start", {31'b0, start_o}, 0);
    check("rst_rvalid", {31'b0, cfg_r_valid_o}, 0);
    check("rst_rdata", cfg_r_data_o, 0);
    check("rst_evt", {24'b0, evt_o}, 0);
    check("rst_swevt", {24'b0, sw_evt_o}, 0);
    check("rst_clear", {31'b0, clear_o}, 0);
    check("rst_prog", {29'b0, prog_valid_o, prog_ctx_o}, 0);
    check("rst_ctx_job", {22'b0, ctx_o, job_id_o}, 0);
    cycles(2);
    rst_ni = 1'b1;
    step();

    // Core 2: acquire, trigger, start timing, done event, FINISHED.
    access(2, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("s1_acq", r, 0);
    check("s1_prog_valid", {31'b0, prog_valid_o}, 1);
    access(2, 0, OFF_TRIGGER, 0, 0, r, ra);
    check("s1_busy_n", {31'b0, busy_o}, 0);
    step();
    check("s1_busy_n1", {31'b0, busy_o}, 1);
    check("s1_start_n1", {31'b0, start_o}, 0);
    step();
    check("s1_start_n2", {31'b0, start_o}, 1);
    step();
    check("s1_start_n3", {31'b0, start_o}, 0);
    pulse_done();
    check("s1_busy_d", {31'b0, busy_o}, 0);
    check("s1_evt_d", {24'b0, evt_o}, 0);
    step();
    check("s1_evt_d1", {24'b0, evt_o}, 32'h04);
    step();
    check("s1_evt_d2", {24'b0, evt_o}, 0);
    access(0, 1, OFF_FINISHED, 0, 0, r, ra);
    check("s1_finished", r, 1);

    // Table: locking, commit-only, full, register map holes.
    do_reset();
    tbl[0]  = '{0, 1'b1, OFF_STATUS,   0, 32'h0};
    tbl[1]  = '{0, 1'b1, OFF_RUNNING,  0, 32'hFFFF_FFFF};
    tbl[2]  = '{1, 1'b1, OFF_ACQUIRE,  0, 32'h0};
    tbl[3]  = '{3, 1'b1, OFF_ACQUIRE,  0, 32'hFFFF_FFFF};
    tbl[4]  = '{1, 1'b1, OFF_ACQUIRE,  0, 32'h0};
    tbl[5]  = '{3, 1'b0, OFF_TRIGGER,  0, 32'h0};
    tbl[6]  = '{0, 1'b1, OFF_STATUS,   0, 32'h200};
    tbl[7]  = '{1, 1'b0, OFF_TRIGGER,  1, 32'h0};
    tbl[8]  = '{0, 1'b1, OFF_STATUS,   0, 32'h001};
    tbl[9]  = '{2, 1'b1, OFF_ACQUIRE,  0, 32'h1};
    tbl[10] = '{2, 1'b0, OFF_TRIGGER,  1, 32'h0};
    tbl[11] = '{5, 1'b1, OFF_ACQUIRE,  0, 32'h2};
    tbl[12] = '{5, 1'b0, OFF_TRIGGER,  1, 32'h0};
    tbl[13] = '{6, 1'b1, OFF_ACQUIRE,  0, 32'h3};
    tbl[14] = '{6, 1'b0, OFF_TRIGGER,  1, 32'h0};
    tbl[15] = '{7, 1'b1, OFF_ACQUIRE,  0, 32'hFFFF_FFFE};
    tbl[16] = '{0, 1'b1, OFF_STATUS,   0, 32'h004};
    tbl[17] = '{0, 1'b1, 3'd7,         0, 32'h0};
    tbl[18] = '{0, 1'b1, OFF_TRIGGER,  0, 32'h0};
    tbl[19] = '{0, 1'b1, OFF_SWEVT,    0, 32'h0};
    tbl[20] = '{0, 1'b0, OFF_FINISHED, 55, 32'h0};
    tbl[21] = '{0, 1'b1, OFF_FINISHED, 0, 32'h0};
    for (int i = 0; i < 22; i++) begin
      access(tbl[i].core, tbl[i].rd, tbl[i].off, tbl[i].data, 0, r, ra);
      if (tbl[i].rd) check($sformatf("tbl%0d", i), r, tbl[i].exp);
    end
    check("tbl_busy_idle", {31'b0, busy_o}, 0);

    // Trigger without a critical section drains the four queued jobs in order.
    owners = '{1, 2, 5, 6};
    access(0, 0, OFF_TRIGGER, 0, 0, r, ra);
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("drain%0d", k), jid);
      check($sformatf("drain%0d_jobid", k), {24'b0, jid}, k);
      pulse_done();
      step();
      check($sformatf("drain%0d_evt", k), {24'b0, evt_o}, 32'(1) << owners[k]);
    end
    access(0, 1, OFF_STATUS, 0, 0, r, ra);
    check("drain_status", r, 0);
    access(0, 1, OFF_FINISHED, 0, 0, r, ra);
    check("drain_finished", r, 4);

    // Commit on the same edge as done.
    do_reset();
    access(0, 1, OFF_ACQUIRE, 0, 0, r, ra);
    access(0, 0, OFF_TRIGGER, 0, 0, r, ra);
    wait_start("same0", jid);
    access(1, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("same_acq", r, 1);
    access(1, 0, OFF_TRIGGER, 1, 1, r, ra);
    check("same_busy", {31'b0, busy_o}, 0);
    access(0, 1, OFF_STATUS, 0, 0, r, ra);
    check("same_status", r, 32'h0001_0401);
    check("same_evt", {24'b0, evt_o}, 32'h01);
    wait_start("same1", jid);
    check("same1_jobid", {24'b0, jid}, 1);
    pulse_done();
    step();
    check("same1_evt", {24'b0, evt_o}, 32'h02);
    access(0, 1, OFF_FINISHED, 0, 0, r, ra);
    check("same_finished", r, 2);
    check("same_ptrs", {28'b0, prog_ctx_o, ctx_o}, 32'b1010);

    // Asynchronous reset in RUN: immediate return, no event afterwards.
    access(3, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("ar_acq", r, 2);
    access(3, 0, OFF_TRIGGER, 0, 0, r, ra);
    wait_start("ar", jid);
    check("ar_busy_pre", {31'b0, busy_o}, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("ar_busy", {31'b0, busy_o}, 0);
    check("ar_ptrs", {28'b0, prog_ctx_o, ctx_o}, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    evt_seen = '0;
    pulse_done();
    cycles(3);
    check("ar_no_evt", {24'b0, evt_seen}, 0);
    access(3, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("ar_acq_after", r, 0);

    // Software events.
    access(0, 0, OFF_SWEVT, 9, 0, r, ra);
    check("swevt9", {24'b0, sw_evt_o}, 0);
    step();
    check("swevt9_next", {24'b0, sw_evt_o}, 0);
    access(0, 0, OFF_SWEVT, 3, 0, r, ra);
    check("swevt3", {24'b0, sw_evt_o}, 32'h08);
    step();
    check("swevt3_next", {24'b0, sw_evt_o}, 0);

    // next_id wraps after 256 commit/done rounds.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      access(i % 8, 1, OFF_ACQUIRE, 0, 0, r, ra);
      check("wrap_acq", r, i);
      access(i % 8, 0, OFF_TRIGGER, 0, 0, r, ra);
      wait_start("wrap", jid);
      pulse_done();
    end
    access(1, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("wrap_acq_final", r, 0);
    access(1, 1, OFF_FINISHED, 0, 0, r, ra);
    check("wrap_finished", r, 256);

    // AUTO_TRIGGER instance and soft clear.
    do_reset();
    access(4, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("auto_acq0", ra, 0);
    access(4, 0, OFF_TRIGGER, 5, 0, r, ra);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (start_a) found = 1'b1;
    end
    check("auto_start_seen", {31'b0, found}, 1);
    check("auto_busy", {31'b0, busy_a}, 1);
    access(4, 0, OFF_SOFT_CLEAR, 7, 0, r, ra);
    check("auto_clear0", {31'b0, clear_a}, 1);
    check("auto_clear_busy", {31'b0, busy_a}, 0);
    access(4, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("auto_acq_in_clear", ra, 0);
    check("auto_clear1", {31'b0, clear_a}, 1);
    step();
    check("auto_clear2", {31'b0, clear_a}, 0);
    access(4, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("auto_acq_kept", ra, 1);
    access(4, 0, OFF_TRIGGER, 1, 0, r, ra);
    cycles(3);
    check("auto_busy2", {31'b0, busy_a}, 1);
    access(4, 0, OFF_SOFT_CLEAR, 0, 0, r, ra);
    cycles(3);
    access(4, 1, OFF_ACQUIRE, 0, 0, r, ra);
    check("auto_acq_zeroed", ra, 0);

    // Random traffic against a queue-level reference model.
    do_reset();
    m_crit = 0; m_trig = 0; m_run = 0; m_owner = 0; m_next = '0; m_fin = '0;
    mq.delete();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      c = $urandom_range(0, 3);
      d = $urandom_range(0, 2);
      if (op >= 8 && !m_run) op = 6;
      evt_seen = '0;
      if (op >= 8) begin
        j = mq.pop_front();
        pulse_done();
        m_fin++;
        m_run = 0;
        if (mq.size() == 0) m_trig = 0;
        exp = 32'(1) << j.owner;
      end else begin
        mask = '1;
        exp = '0;
        if (op <= 2) begin
          if (!m_crit && mq.size() < 4) begin exp = m_next; m_crit = 1; m_owner = c; end
          else if (m_crit && c == m_owner) exp = m_next;
          else if (m_crit) exp = 32'hFFFF_FFFF;
          else exp = 32'hFFFF_FFFE;
          access(c, 1, OFF_ACQUIRE, 0, 0, r, ra);
        end else if (op <= 5) begin
          if (m_crit && c == m_owner) begin
            mq.push_back('{c, m_next});
            m_next = m_next + 8'd1;
            m_crit = 0;
            if (d == 0) m_trig = 1;
          end else if (!m_crit && d == 0) m_trig = 1;
          access(c, 0, OFF_TRIGGER, d, 0, r, ra);
          r = '0;
        end else if (op == 6) begin
          exp = 32'(mq.size()) | (32'(m_run) << 8) | (32'(m_crit) << 9) | (32'(m_trig) << 10);
          if (mq.size() > 0) exp |= 32'(mq[0].id) << 16;
          else mask = 32'hFF00_FFFF;
          access(c, 1, OFF_STATUS, 0, 0, r, ra);
        end else begin
          exp = m_run ? 32'(mq[0].id) : 32'hFFFF_FFFF;
          access(c, 1, OFF_RUNNING, 0, 0, r, ra);
        end
        check($sformatf("rnd%0d_op%0d_rdata", n, op), r & mask, exp & mask);
        exp = '0;
      end
      if (!m_run && mq.size() > 0 && m_trig) m_run = 1;
      cycles(3);
      check($sformatf("rnd%0d_evt", n), {24'b0, evt_seen}, exp);
      check($sformatf("rnd%0d_busy", n), {31'b0, busy_o}, {31'b0, m_run});
    end
    access(0, 1, OFF_FINISHED, 0, 0, r, ra);
    check("rnd_finished", r, m_fin);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
